// File: rtl/fpnew_result_reorder_buffer.sv
// fpnew_result_reorder_buffer
//   In-order writeback buffer for an FPU operation group. A slot ID is handed
//   out at issue and travels through the operation group as the op tag.
//   Results may come back in any order; they are released to the writeback
//   port strictly in issue order together with the caller's original tag.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous flush of every slot (blocks all handshakes)
//   issue_*             slot allocation handshake; issue_id_o = allocated ID
//   res_*               out-of-order result return, addressed by slot ID
//   out_*               in-order writeback of the head slot
//   count_o, busy_o     number of allocated slots, non-empty flag
//   err_o               sticky protocol error (bad or duplicate result ID)
module fpnew_result_reorder_buffer #(
  parameter int Width    = 32,
  parameter int Depth    = 4,
  parameter int TagWidth = 8,
  localparam int IdWidth = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [TagWidth-1:0] issue_tag_i,
  output logic [IdWidth-1:0]  issue_id_o,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic [IdWidth-1:0]  res_id_i,
  input  logic [Width-1:0]    res_result_i,
  input  logic [4:0]          res_status_i,
  input  logic                res_ext_bit_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    out_result_o,
  output logic [4:0]          out_status_o,
  output logic                out_ext_bit_o,
  output logic [TagWidth-1:0] out_tag_o,
  output logic [IdWidth:0]    count_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [IdWidth:0]   CountMax = (IdWidth+1)'(Depth);
  localparam logic [IdWidth:0]   CntOne   = (IdWidth+1)'(1);
  localparam logic [IdWidth-1:0] IdOne    = IdWidth'(1);

  logic [Depth-1:0]    r_alloc;
  logic [Depth-1:0]    r_done;
  logic [TagWidth-1:0] r_tag    [Depth];
  logic [Width-1:0]    r_result [Depth];
  logic [4:0]          r_status [Depth];
  logic [Depth-1:0]    r_ext;
  logic [IdWidth-1:0]  r_wr_ptr;
  logic [IdWidth-1:0]  r_rd_ptr;
  logic [IdWidth:0]    r_count;
  logic                r_err;

  logic w_issue_hs;
  logic w_res_hs;
  logic w_res_slot_open;
  logic w_res_ok;
  logic w_res_err;
  logic w_retire_hs;

  // Ready is taken from the registered count only: a full buffer that
  // retires this cycle still refuses the issue (no bypass path).
  assign issue_ready_o = (r_count < CountMax) && !flush_i;
  assign issue_id_o    = r_wr_ptr;
  assign res_ready_o   = !flush_i;

  assign w_issue_hs      = issue_valid_i & issue_ready_o;
  assign w_res_hs        = res_valid_i & res_ready_o;
  // Uses pre-edge alloc, so a result aimed at the slot being allocated in
  // the same cycle is rejected as an error.
  assign w_res_slot_open = r_alloc[res_id_i] & ~r_done[res_id_i];
  assign w_res_ok        = w_res_hs & w_res_slot_open;
  assign w_res_err       = w_res_hs & ~w_res_slot_open;

  // Writeback is driven purely from stored state; no res_* -> out_* path.
  assign out_valid_o   = r_alloc[r_rd_ptr] & r_done[r_rd_ptr] & !flush_i;
  assign out_result_o  = r_result[r_rd_ptr];
  assign out_status_o  = r_status[r_rd_ptr];
  assign out_ext_bit_o = r_ext[r_rd_ptr];
  assign out_tag_o     = r_tag[r_rd_ptr];
  assign w_retire_hs   = out_valid_o & out_ready_i;

  assign count_o = r_count;
  assign busy_o  = (r_count != '0);
  assign err_o   = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alloc  <= '0;
      r_done   <= '0;
      r_ext    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        r_tag[i]    <= '0;
        r_result[i] <= '0;
        r_status[i] <= '0;
      end
    end else if (flush_i) begin
      // Control state only; stale data fields are harmless once alloc is 0.
      r_alloc  <= '0;
      r_done   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      // Issue, result and retire always address distinct slots when they
      // coincide, so the three updates below never collide.
      if (w_issue_hs) begin
        r_alloc[r_wr_ptr] <= 1'b1;
        r_done[r_wr_ptr]  <= 1'b0;
        r_tag[r_wr_ptr]   <= issue_tag_i;
        r_wr_ptr          <= r_wr_ptr + IdOne;
      end
      if (w_res_ok) begin
        r_result[res_id_i] <= res_result_i;
        r_status[res_id_i] <= res_status_i;
        r_ext[res_id_i]    <= res_ext_bit_i;
        r_done[res_id_i]   <= 1'b1;
      end
      if (w_retire_hs) begin
        r_alloc[r_rd_ptr] <= 1'b0;
        r_done[r_rd_ptr]  <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + IdOne;
      end
      if (w_res_err) begin
        r_err <= 1'b1;
      end
      case ({w_issue_hs, w_retire_hs})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fpnew_result_reorder_buffer.sv
module tb_fpnew_result_reorder_buffer;

  localparam int Depth = 4;

  logic        clk;
  logic        rst_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [7:0]  issue_tag_i;
  logic [1:0]  issue_id_o;
  logic        res_valid_i, res_ready_o;
  logic [1:0]  res_id_i;
  logic [31:0] res_result_i;
  logic [4:0]  res_status_i;
  logic        res_ext_bit_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_status_o;
  logic        out_ext_bit_o;
  logic [7:0]  out_tag_o;
  logic [2:0]  count_o;
  logic        busy_o, err_o;

  fpnew_result_reorder_buffer #(.Width(32), .Depth(Depth), .TagWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_tag_i(issue_tag_i), .issue_id_o(issue_id_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_id_i(res_id_i),
    .res_result_i(res_result_i), .res_status_i(res_status_i),
    .res_ext_bit_i(res_ext_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_status_o(out_status_o),
    .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
    .count_o(count_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the list of outstanding operations in issue order.
  typedef struct {
    int          id;
    logic [7:0]  tag;
    bit          done;
    logic [31:0] res;
    logic [4:0]  st;
    logic        ext;
  } ent_t;

  ent_t q[$];
  int   m_wr;
  bit   m_err;
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input int id);
    for (int i = 0; i < q.size(); i++) if (q[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_wr  = 0;
    m_err = 0;
  endtask

  task automatic cmp_model();
    bit e_ov;
    e_ov = (q.size() > 0) && q[0].done && !flush_i;
    chk("issue_ready", issue_ready_o, (q.size() < Depth) && !flush_i);
    chk("issue_id", issue_id_o, m_wr);
    chk("res_ready", res_ready_o, !flush_i);
    chk("out_valid", out_valid_o, e_ov);
    chk("count", count_o, q.size());
    chk("busy", busy_o, q.size() != 0);
    chk("err", err_o, m_err);
    if (e_ov) begin
      chk("out_result", out_result_o, q[0].res);
      chk("out_status", out_status_o, q[0].st);
      chk("out_ext", out_ext_bit_o, q[0].ext);
      chk("out_tag", out_tag_o, q[0].tag);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model with the
  // handshakes that the rising edge commits.
  task automatic tick();
    bit hs_iss, hs_ret, hs_res, fl;
    int rid, idx;
    logic [31:0] rdat;
    logic [4:0]  rst_v;
    logic        rext;
    logic [7:0]  itag;
    ent_t e;
    @(negedge clk);
    cmp_model();
    fl     = flush_i;
    hs_iss = issue_valid_i && (q.size() < Depth) && !fl;
    hs_ret = out_ready_i && (q.size() > 0) && q[0].done && !fl;
    hs_res = res_valid_i && !fl;
    rid    = int'(res_id_i);
    rdat   = res_result_i;
    rst_v  = res_status_i;
    rext   = res_ext_bit_i;
    itag   = issue_tag_i;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      if (hs_res) begin
        idx = find(rid);
        if (idx < 0 || q[idx].done) m_err = 1;
        else begin
          q[idx].done = 1;
          q[idx].res  = rdat;
          q[idx].st   = rst_v;
          q[idx].ext  = rext;
        end
      end
      if (hs_ret) void'(q.pop_front());
      if (hs_iss) begin
        e.id = m_wr; e.tag = itag; e.done = 0; e.res = '0; e.st = '0; e.ext = 1'b0;
        q.push_back(e);
        m_wr = (m_wr + 1) % Depth;
      end
    end
    #1;
  endtask

  task automatic idle();
    flush_i = 0; issue_valid_i = 0; res_valid_i = 0; out_ready_i = 0;
    res_status_i = '0; res_ext_bit_i = 0;
  endtask

  task automatic do_flush();
    flush_i = 1; tick(); flush_i = 0;
  endtask

  task automatic do_issue(input logic [7:0] tag);
    issue_valid_i = 1; issue_tag_i = tag; tick(); issue_valid_i = 0;
  endtask

  task automatic do_res(input logic [1:0] id, input logic [31:0] d);
    res_valid_i = 1; res_id_i = id; res_result_i = d; tick(); res_valid_i = 0;
  endtask

  task automatic chk_reset_values(input string p);
    chk({p, "_issue_ready"}, issue_ready_o, 1);
    chk({p, "_issue_id"}, issue_id_o, 0);
    chk({p, "_res_ready"}, res_ready_o, 1);
    chk({p, "_out_valid"}, out_valid_o, 0);
    chk({p, "_count"}, count_o, 0);
    chk({p, "_busy"}, busy_o, 0);
    chk({p, "_err"}, err_o, 0);
    chk({p, "_out_result"}, out_result_o, 0);
    chk({p, "_out_status"}, out_status_o, 0);
    chk({p, "_out_ext"}, out_ext_bit_o, 0);
    chk({p, "_out_tag"}, out_tag_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_res;
    logic [7:0]  s_tag;
    n_vec = 0; n_bad = 0;
    idle();
    issue_tag_i = '0; res_id_i = '0; res_result_i = '0;
    rst_i = 1;
    model_reset();
    #1;
    chk_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst_i = 0;

    // In-order single op
    do_issue(8'h11);
    do_res(2'd0, 32'h3F800000);
    #1;
    chk("single_valid", out_valid_o, 1);
    chk("single_result", out_result_o, 32'h3F800000);
    chk("single_tag", out_tag_o, 8'h11);
    out_ready_i = 1; tick(); out_ready_i = 0;
    #1 chk("single_count", count_o, 0);

    // Out-of-order return
    do_flush();
    do_issue(8'hAA); do_issue(8'hBB); do_issue(8'hCC);
    do_res(2'd2, 32'h0000_0C0C);
    #1 chk("ooo_wait_valid", out_valid_o, 0);
    do_res(2'd0, 32'h0000_0A0A);
    #1 chk("ooo_head_valid", out_valid_o, 1);
    chk("ooo_tag_a", out_tag_o, 8'hAA);
    out_ready_i = 1;
    do_res(2'd1, 32'h0000_0B0B);
    #1 chk("ooo_tag_b", out_tag_o, 8'hBB);
    chk("ooo_res_b", out_result_o, 32'h0000_0B0B);
    tick();
    #1 chk("ooo_tag_c", out_tag_o, 8'hCC);
    tick();
    #1 chk("ooo_count", count_o, 0);
    out_ready_i = 0;

    // Full and wrap-around
    do_flush();
    for (int i = 0; i < 4; i++) do_issue(8'hA0 + 8'(i));
    #1 chk("full_ready", issue_ready_o, 0);
    chk("full_count", count_o, 4);
    do_res(2'd0, 32'h1000_0000);
    out_ready_i = 1; issue_valid_i = 1; issue_tag_i = 8'hA4;
    #1 chk("full_retire_ready", issue_ready_o, 0);
    tick();
    out_ready_i = 0;
    #1 chk("after_retire_ready", issue_ready_o, 1);
    chk("wrap_id", issue_id_o, 0);
    tick();
    issue_valid_i = 0;
    out_ready_i = 1;
    do_res(2'd3, 32'h1000_0003);
    do_res(2'd2, 32'h1000_0002);
    do_res(2'd1, 32'h1000_0001);
    #1 chk("wrap_tag1", out_tag_o, 8'hA1);
    do_res(2'd0, 32'h1000_0004);
    repeat (4) tick();
    #1 chk("wrap_count", count_o, 0);
    out_ready_i = 0;

    // Backpressure
    do_flush();
    do_issue(8'h42);
    do_res(2'd0, 32'hCAFE_F00D);
    s_res = out_result_o; s_tag = out_tag_o;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid_o, 1);
      chk("bp_result_stable", out_result_o, s_res);
      chk("bp_tag_stable", out_tag_o, s_tag);
      tick();
    end
    out_ready_i = 1; tick(); out_ready_i = 0;
    #1 chk("bp_count", count_o, 0);

    // Protocol errors
    do_flush();
    do_res(2'd3, 32'hBAD0_0003);
    #1 chk("err_unalloc", err_o, 1);
    chk("err_unalloc_count", count_o, 0);
    do_flush();
    #1 chk("err_cleared", err_o, 0);
    do_issue(8'h55);
    do_res(2'd0, 32'h1234_5678);
    do_res(2'd0, 32'hDEAD_BEEF);
    #1 chk("err_dup", err_o, 1);
    chk("err_dup_keep", out_result_o, 32'h1234_5678);
    out_ready_i = 1; tick(); out_ready_i = 0;

    // Flush mid-flight
    do_flush();
    do_issue(8'h01); do_issue(8'h02); do_issue(8'h03);
    do_res(2'd0, 32'h0000_0001);
    flush_i = 1; issue_valid_i = 1; issue_tag_i = 8'h04; out_ready_i = 1;
    #1 chk("flush_blocks_issue", issue_ready_o, 0);
    chk("flush_blocks_res", res_ready_o, 0);
    chk("flush_blocks_out", out_valid_o, 0);
    tick();
    idle();
    #1 chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_err", err_o, 0);
    chk("flush_id", issue_id_o, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int pick;
      int open_ids[$];
      open_ids.delete();
      foreach (q[k]) if (!q[k].done) open_ids.push_back(q[k].id);
      flush_i       = ($urandom_range(0, 59) == 0);
      issue_valid_i = ($urandom_range(0, 2) != 0);
      issue_tag_i   = 8'($urandom);
      res_valid_i   = ($urandom_range(0, 2) != 0);
      if (open_ids.size() > 0 && $urandom_range(0, 9) != 0) begin
        pick = open_ids[$urandom_range(0, open_ids.size() - 1)];
        res_id_i = 2'(pick);
      end else begin
        res_id_i = 2'($urandom_range(0, 3));
      end
      res_result_i  = $urandom;
      res_status_i  = 5'($urandom);
      res_ext_bit_i = 1'($urandom);
      out_ready_i   = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();

    // Asynchronous reset between edges with slots in flight
    do_flush();
    do_issue(8'h71); do_issue(8'h72); do_issue(8'h73);
    do_res(2'd0, 32'h7777_0000);
    #2 rst_i = 1;
    #1;
    model_reset();
    chk_reset_values("async_rst");
    rst_i = 0;
    tick();
    do_issue(8'h99);
    #1 chk("post_rst_count", count_o, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fpnew_result_reorder_buffer.md
# fpnew_result_reorder_buffer

In-order writeback buffer placed downstream of an FPU operation-group block. At issue time it allocates a slot ID, which travels through the operation group as the operation tag. It then accepts results that return out of order, for example across format slices or through the round-robin output arbiter. Results are delivered to the writeback port strictly in issue order, each with the caller's original tag.

## Interface
Parameters:
- Width, 32, result width in bits.
- Depth, 4, number of slots; a power of two, ≥ 2.
- TagWidth, 8, width of the caller tag stored per slot.
- IdWidth, localparam = $clog2(Depth), slot ID width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous flush of all slots.
- issue_valid_i  in  1  request to allocate a slot.
- issue_ready_o  out  1  slot available.
- issue_tag_i  in  TagWidth  caller tag to store in the slot.
- issue_id_o  out  IdWidth  ID of the slot allocated on handshake; the caller attaches it as the operation tag.
- res_valid_i  in  1  a result is returning.
- res_ready_o  out  1  result accepted.
- res_id_i  in  IdWidth  slot ID carried back as the result tag.
- res_result_i  in  Width  result data.
- res_status_i  in  5  fpnew_pkg::status_t flags {NV,DZ,OF,UF,NX}.
- res_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  head slot is complete.
- out_ready_i  in  1  writeback consumer accepts.
- out_result_o  out  Width  head slot result.
- out_status_o  out  5  head slot status.
- out_ext_bit_o  out  1  head slot extension bit.
- out_tag_o  out  TagWidth  head slot caller tag.
- count_o  out  IdWidth+1  number of allocated slots.
- busy_o  out  1  count_o != 0.
- err_o  out  1  sticky protocol error.

## Operation
- **Storage**: circular array of Depth slots. Each slot holds {alloc, done, tag, result, status, ext}. State is an allocation pointer (wr_ptr), a retire pointer (rd_ptr) and count; both pointers are IdWidth bits and wrap naturally from Depth-1 to 0.
- **Issue**:
  - issue_ready_o = (count < Depth) & !flush_i.
  - issue_id_o = wr_ptr at all times.
  - On issue_valid_i & issue_ready_o: slot[wr_ptr] gets alloc=1, done=0, tag=issue_tag_i; wr_ptr++ and count++.
- **Result**:
  - res_ready_o = !flush_i.
  - On res_valid_i & res_ready_o with slot[res_id_i].alloc=1 and done=0: store result, status and ext; set done=1.
  - If the addressed slot is unallocated or already done: discard the data, leave the slot unchanged, and set err_o.
- **Retire**:
  - out_valid_o = slot[rd_ptr].alloc & slot[rd_ptr].done & !flush_i.
  - out_* outputs are driven from slot[rd_ptr] and are stable while out_valid_o=1 and out_ready_i=0.
  - On handshake: clear alloc and done, rd_ptr++, count--.
- **Simultaneous events**:
  - Issue and retire in the same cycle leave count unchanged.
  - Full with retire in the same cycle: issue_ready_o stays 0, because it is computed from the registered count (no bypass).
  - A result write and a retire in the same cycle always target different slots; both take effect.
  - A result addressed to the slot being allocated in the same cycle sees the pre-edge alloc=0, is an error and is discarded.
- **Flush**: flush_i=1 blocks all three handshakes in that cycle. At the edge it clears wr_ptr, rd_ptr, count, every alloc/done bit and err_o. Data fields are not cleared.
- **Reset (rst_i=1)**:
  - Same effect as a flush, applied immediately and asynchronously.
  - Output values: issue_ready_o=1, issue_id_o=0, res_ready_o=1, out_valid_o=0, count_o=0, busy_o=0, err_o=0.
  - out_result_o, out_status_o, out_ext_bit_o and out_tag_o are 0 (data fields reset to 0).
  - Reset asserted mid-operation drops all in-flight slots.

## Timing
- Issue to ID: zero-cycle; issue_id_o is valid in the handshake cycle.
- Result to writeback: at least 1 cycle. A result accepted at edge t for the head slot gives out_valid_o=1 in cycle t+1. There is no combinational path from res_* to out_*.
- Non-head results wait until every older slot has retired.
- Throughput: one issue, one result and one retire per cycle sustained.
- err_o: rises the cycle after the offending handshake and holds until reset or flush.

## Test plan
- **In-order single op**, Depth=4: issue tag 0x11 (ID 0), result ID 0 = 0x3F800000 with status 0 → next cycle out_valid_o=1, out_result_o=0x3F800000, out_tag_o=0x11, then count_o=0.
- **Out-of-order return**: issue tags A, B, C (IDs 0, 1, 2); return results in order 2, 0, 1.
  - out_valid_o rises only after ID 0 returns.
  - Writeback order is A, B, C back-to-back with out_ready_i=1.
- **Full and wrap-around**:
  - Issue 4 → issue_ready_o=0, count_o=4.
  - Complete and retire ID 0 → issue_ready_o=1 the following cycle.
  - Next issue gets ID 0 again; retire order continues 1, 2, 3, 0.
- **Backpressure**: head done with out_ready_i=0 for 5 cycles → out_* stable. Then retire on out_ready_i=1.
- **Protocol error**: result to unallocated ID 3 → err_o=1 next cycle and no slot changes. A duplicate result to a done slot also sets err_o; the original data is retained.
- **Flush and reset mid-flight**:
  - With 3 slots pending, pulse flush_i → count_o=0, out_valid_o=0, err_o=0, and the next issue gets ID 0.
  - Assert rst_i asynchronously between edges → outputs take reset values immediately.
